// File: rtl/inst_fetch.sv
// inst_fetch: sequential instruction fetch with a 2-entry {pc, inst} buffer in front of a synchronous ROM.
//   clka        : clock, all state changes on the rising edge
//   rsta        : synchronous active-high reset
//   imem_addr   : word address to the ROM (data returns one edge later on imem_data)
//   out_valid/out_ready/out_inst/out_pc : head of the buffer towards the execute stage
//   redirect_en/redirect_pc : restart fetch at a new address (only with INST_FETCH_REDIRECT_EN defined)
module inst_fetch #(
   parameter int          ADDR_W   = 6,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clka,
   input  logic              rsta,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_inst,
   output logic [31:0]       out_pc,
   input  logic              redirect_en,
   input  logic [31:0]       redirect_pc
);
   logic [31:0] pc, inflight_pc, target;
   logic [31:0] fifo_pc [2];
   logic [31:0] fifo_inst [2];
   logic [1:0]  count, occ, after_pop;
   logic        inflight, pop, redir, issue;
`ifdef INST_FETCH_REDIRECT_EN
   logic unused_redirect;
   assign redir = redirect_en;
   assign target = {redirect_pc[31:2], 2'b00};
   assign unused_redirect = ^redirect_pc[1:0];
`else
   logic unused_redirect;
   assign redir = 1'b0;
   assign target = '0;
   assign unused_redirect = ^{redirect_en, redirect_pc};
`endif
   always_comb begin
      out_valid = count != 2'd0;
      out_pc    = out_valid ? fifo_pc[0] : '0;
      out_inst  = out_valid ? fifo_inst[0] : '0;
      imem_addr = pc[ADDR_W+1:2];
      pop       = out_valid & out_ready;
      after_pop = count - {1'b0, pop};
      // occupancy after this edge: the in-flight read lands in the buffer
      occ       = after_pop + {1'b0, inflight};
      issue     = ~redir & (occ < 2'd2);
   end
   always_ff @(posedge clka) begin
      if (rsta) begin
         pc       <= RESET_PC;
         count    <= '0;
         inflight <= 1'b0;
      end else if (redir) begin
         pc       <= target;
         count    <= '0;
         inflight <= 1'b0;
      end else begin
         if (pop) begin
            fifo_pc[0]   <= fifo_pc[1];
            fifo_inst[0] <= fifo_inst[1];
         end
         if (inflight) begin
            fifo_pc[after_pop[0]]   <= inflight_pc;
            fifo_inst[after_pop[0]] <= imem_data;
         end
         count    <= occ;
         inflight <= issue;
         if (issue) begin
            inflight_pc <= pc;
            pc          <= pc + 32'd4;
         end
      end
   end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized self-checking bench for inst_fetch against a queue-based fetch model.
module tb_inst_fetch;
   localparam int AW = 6;
`ifdef INST_FETCH_REDIRECT_EN
   localparam bit REDIR = 1'b1;
`else
   localparam bit REDIR = 1'b0;
`endif
   logic clka = 1'b0;
   always #5 clka = ~clka;

   logic          rsta = 1'b1, out_ready = 1'b0, redirect_en = 1'b0;
   logic [31:0]   redirect_pc = '0;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_data, out_inst, out_pc;
   logic          out_valid;

   inst_fetch #(.ADDR_W(AW), .RESET_PC(32'h0)) dut (
      .clka(clka), .rsta(rsta), .imem_addr(imem_addr), .imem_data(imem_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
      .redirect_en(redirect_en), .redirect_pc(redirect_pc));
   always_ff @(posedge clka) imem_data <= 32'h1000_0000 + 32'(imem_addr);

   logic          rst2 = 1'b1;
   logic [AW-1:0] addr2;
   logic [31:0]   data2, inst2, pc2;
   logic          valid2;
   inst_fetch #(.ADDR_W(AW), .RESET_PC(32'h0000_00FC)) dut2 (
      .clka(clka), .rsta(rst2), .imem_addr(addr2), .imem_data(data2),
      .out_valid(valid2), .out_ready(1'b1), .out_inst(inst2), .out_pc(pc2),
      .redirect_en(1'b0), .redirect_pc(32'h0));
   always_ff @(posedge clka) data2 <= 32'h1000_0000 + 32'(addr2);

   int tests = 0, fails = 0;
   // model: buffered pcs, outstanding fetch pcs, next fetch pc
   logic [31:0] q[$], pend[$], mpc;

   function automatic logic [31:0] rom_of(input logic [31:0] pc);
      return 32'h1000_0000 + 32'(pc[AW+1:2]);
   endfunction

   function automatic logic [70:0] expv();
      logic v;
      v = q.size() > 0;
      return {v, v ? q[0] : 32'h0, v ? rom_of(q[0]) : 32'h0, mpc[AW+1:2]};
   endfunction

   task automatic tick(input logic r, input logic rdy, input logic re, input logic [31:0] rpc);
      rsta = r; out_ready = rdy; redirect_en = re; redirect_pc = rpc;
      @(posedge clka);
      if (r) begin
         q.delete(); pend.delete(); mpc = 32'h0;
      end else begin
         if (q.size() > 0 && rdy) void'(q.pop_front());
         if (re && REDIR) begin
            q.delete(); pend.delete(); mpc = {rpc[31:2], 2'b00};
         end else begin
            if (pend.size() > 0) q.push_back(pend.pop_front());
            if (q.size() < 2) begin pend.push_back(mpc); mpc += 32'd4; end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      tick(1, 1, 0, 0);
      tick(1, 0, 1, 32'h40);
      tests += 4;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      if (out_pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want 0", out_pc); end
      if (out_inst !== 32'h0) begin fails++; $display("FAIL reset_inst: got %h want 0", out_inst); end
      if (imem_addr !== '0) begin fails++; $display("FAIL reset_addr: got %0d want 0", imem_addr); end
   endtask

   task automatic test_stream();
      tick(1, 1, 0, 0);
      for (int i = 0; i < 12; i++) begin
         tick(0, 1, 0, 0);
         tests++;
         if ({out_valid, out_pc, out_inst, imem_addr} !== expv()) begin
            fails++; $display("FAIL stream[%0d]: got %h want %h", i, {out_valid, out_pc, out_inst, imem_addr}, expv());
         end
         tests++;
         if (i >= 1 && (out_pc !== 32'(4 * (i - 1)) || out_inst !== 32'h1000_0000 + 32'(i - 1) || !out_valid)) begin
            fails++; $display("FAIL stream_seq[%0d]: got pc %h inst %h v %b want pc %h", i, out_pc, out_inst, out_valid, 32'(4 * (i - 1)));
         end else if (i == 0 && out_valid !== 1'b0) begin
            fails++; $display("FAIL stream_first: got valid %b after 1st edge want 0", out_valid);
         end
      end
   endtask

   task automatic test_backpressure();
      tick(1, 0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         tick(0, 0, 0, 0);
         tests++;
         if ({out_valid, out_pc, out_inst, imem_addr} !== expv()) begin
            fails++; $display("FAIL stall[%0d]: got %h want %h", i, {out_valid, out_pc, out_inst, imem_addr}, expv());
         end
      end
      tests += 2;
      if (imem_addr !== AW'(2) || out_pc !== 32'h0) begin
         fails++; $display("FAIL stall_hold: got addr %0d pc %h want addr 2 pc 0", imem_addr, out_pc);
      end
      if (dut.count !== 2'd2) begin fails++; $display("FAIL stall_count: got %0d want 2", dut.count); end
      for (int k = 1; k <= 5; k++) begin
         tick(0, 1, 0, 0);
         tests++;
         if (!out_valid || out_pc !== 32'(4 * k) || out_inst !== 32'h1000_0000 + 32'(k)) begin
            fails++; $display("FAIL release[%0d]: got pc %h inst %h v %b want pc %h", k, out_pc, out_inst, out_valid, 32'(4 * k));
         end
      end
   endtask

   task automatic test_redirect(input logic rdy_at_redirect);
      tick(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) tick(0, i == 3, 0, 0);
      tick(0, rdy_at_redirect, 1, 32'h0000_0023);
      for (int i = 0; i < 6; i++) begin
         tests++;
         if ({out_valid, out_pc, out_inst, imem_addr} !== expv()) begin
            fails++; $display("FAIL redirect%0d[%0d]: got %h want %h", rdy_at_redirect, i, {out_valid, out_pc, out_inst, imem_addr}, expv());
         end
         tick(0, 1, 0, 0);
      end
   endtask

   task automatic test_reset_mid();
      tick(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);
      tick(1, 1, 1, 32'h80);
      tests++;
      if ({out_valid, out_pc, out_inst} !== 65'h0) begin
         fails++; $display("FAIL reset_mid: got v %b pc %h inst %h want all 0", out_valid, out_pc, out_inst);
      end
      for (int i = 0; i < 4; i++) begin
         tick(0, 1, 0, 0);
         tests++;
         if ({out_valid, out_pc, out_inst, imem_addr} !== expv()) begin
            fails++; $display("FAIL refetch[%0d]: got %h want %h", i, {out_valid, out_pc, out_inst, imem_addr}, expv());
         end
      end
   endtask

   task automatic test_wrap();
      rst2 = 1'b1;
      @(posedge clka); #1;
      rst2 = 1'b0;
      tests++;
      if (addr2 !== AW'(63)) begin fails++; $display("FAIL wrap_addr0: got %0d want 63", addr2); end
      @(posedge clka); #1;
      tests++;
      if (addr2 !== AW'(0)) begin fails++; $display("FAIL wrap_addr1: got %0d want 0", addr2); end
      @(posedge clka); #1;
      tests++;
      if (!valid2 || pc2 !== 32'hFC || inst2 !== 32'h1000_003F) begin
         fails++; $display("FAIL wrap_out0: got v %b pc %h inst %h want pc fc inst 1000003f", valid2, pc2, inst2);
      end
      @(posedge clka); #1;
      tests++;
      if (!valid2 || pc2 !== 32'h100 || inst2 !== 32'h1000_0000) begin
         fails++; $display("FAIL wrap_out1: got v %b pc %h inst %h want pc 100 inst 10000000", valid2, pc2, inst2);
      end
   endtask

   task automatic test_random();
      tick(1, 0, 0, 0);
      for (int i = 0; i < 400; i++) begin
         tick($urandom_range(49) == 0, $urandom_range(3) != 0, $urandom_range(9) == 0, $urandom);
         tests++;
         if ({out_valid, out_pc, out_inst, imem_addr} !== expv()) begin
            fails++; $display("FAIL random[%0d]: got %h want %h", i, {out_valid, out_pc, out_inst, imem_addr}, expv());
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect(1'b0);
      test_redirect(1'b1);
      test_reset_mid();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
